sys_arr_feeder: RTL and testbench
=================================

Name: sys_arr_feeder

Overview:
- Input-setup stage directly upstream of the systolic array (`sysArr`).
- Reads input row vectors from the unified input buffer (one `width_height`-lane vector per address, 1-cycle read latency).
- Skews the vectors diagonally (lane i delayed by i cycles) and drives the array's `datain` and `active` ports.
- Signals completion to the controller when the last skewed element has left.

Parameters:
- width_height, 4, array dimension (lanes per vector)
- ADDR_W, 8, buffer address width and row-count width
- localparam data_width = 8*width_height, packed lane data width (lane i = bits [8i+7:8i])

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle request; sampled only in IDLE
- base_addr  in  ADDR_W  buffer address of first row; latched on accepted start
- num_rows  in  ADDR_W  number of rows to stream; latched on accepted start
- rd_en  out  1  buffer read strobe
- rd_addr  out  ADDR_W  buffer read address
- rd_data  in  data_width  buffer read data, valid the cycle after rd_en
- datain  out  data_width  skewed data to `sysArr.datain`
- active  out  1  to `sysArr.active`
- busy  out  1  high from accepted start until the done cycle, inclusive
- done  out  1  one-cycle completion pulse

Behaviour:
- Reset values:
  - All outputs 0.
  - Skew registers and counters cleared; FSM in IDLE.
  - Reset asserted mid-operation aborts immediately; no done pulse.
- States: IDLE, FETCH, DRAIN, FINISH.
- Accepted start = start high in IDLE.
  - Latches base_addr and num_rows; sets busy.
  - If num_rows != 0, goes to FETCH.
  - If num_rows == 0, goes to FINISH: no reads, active never asserts, done pulses the cycle after start.
- start outside IDLE is ignored.
- FETCH:
  - rd_en=1 for exactly num_rows consecutive cycles.
  - rd_addr = base_addr, base_addr+1, … (mod 2^ADDR_W; wrap permitted).
  - After the last read, go to DRAIN.
- Skew:
  - Lane i of row r is driven on `datain` in cycle C0+r+i.
  - C0 = the cycle two cycles after the accepted start: first rd_en cycle + 1 (read latency), with the output registered.
  - Any lane not carrying a valid element in a cycle drives 0x00, including during fill and drain.
  - Example (width_height=4, 4 rows of 0x01 bytes): `datain` = 0000_0001, 0000_0101, 0001_0101, 0101_0101, 0101_0100, 0101_0000, 0100_0000, then 0.
- active:
  - High for exactly num_rows+width_height-1 consecutive cycles, C0 through C0+num_rows+width_height-2.
  - Registered; changes in the same cycle as the corresponding `datain`.
- DRAIN: counts out the remaining width_height-1 skew cycles after the last read, then goes to FINISH.
- FINISH:
  - done=1 for one cycle, in the cycle after active's last high cycle.
  - busy falls after this cycle; return to IDLE.
- A new start is accepted in the cycle after done, at the earliest.
- Vector width: lane data is passed through unmodified; no arithmetic.

Optional Feature:
- Macro: SYS_ARR_FEEDER_ABORT_EN.
- Defined: adds input port `abort` (1 bit) and output port `aborted` (1 bit).
  - abort high while busy, on the next edge: state → IDLE, skew registers zeroed, `datain`=0, active=0, rd_en=0, busy=0.
  - `aborted` pulses for that one cycle; done is not pulsed.
  - abort in IDLE has no effect.
  - abort wins over a simultaneous start.
- Undefined: ports absent; only reset terminates an operation.

Test Plan:
- Reset, then start with base_addr=0x10, num_rows=4, buffer rows all 0x01010101.
  - rd_addr 0x10–0x13 on 4 consecutive cycles.
  - `datain` sequence exactly as in the Behaviour example.
  - active high 7 cycles; done on the 8th; busy low afterwards.
- Distinct rows (row r lane i = 0x10*r+i), num_rows=3.
  - Lane i of row r appears at C0+r+i, all other lanes 0.
  - active high 6 cycles.
- num_rows=0.
  - No rd_en, active stays 0.
  - done pulses the cycle after start.
- base_addr=0xFE, num_rows=4 → rd_addr 0xFE, 0xFF, 0x00, 0x01.
- start re-asserted during FETCH is ignored (single done); reset asserted during DRAIN clears all outputs to 0 the next cycle with no done pulse.
- SYS_ARR_FEEDER_ABORT_EN defined: abort in the 3rd active cycle.
  - Next cycle: active=0, `datain`=0, aborted=1, done=0.
  - A subsequent start runs normally.

Source files
------------

// File: rtl/sys_arr_feeder.sv
// Diagonal-skew input feeder for the systolic array.
// Optional abort port pair: define SYS_ARR_FEEDER_ABORT_EN.
module sys_arr_feeder #(
    parameter  int width_height = 4,
    parameter  int ADDR_W       = 8,
    localparam int data_width   = 8 * width_height
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_W-1:0]     base_addr,
    input  logic [ADDR_W-1:0]     num_rows,
`ifdef SYS_ARR_FEEDER_ABORT_EN
    input  logic                  abort,
    output logic                  aborted,
`endif
    output logic                  rd_en,
    output logic [ADDR_W-1:0]     rd_addr,
    input  logic [data_width-1:0] rd_data,
    output logic [data_width-1:0] datain,
    output logic                  active,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN,
        FINISH
    } state_t;

    state_t            state, nstate;
    logic [ADDR_W-1:0] addr, addr_n;
    logic [ADDR_W-1:0] cnt, cnt_n;
    logic [width_height-1:0] vsh;
    logic              kill;

`ifdef SYS_ARR_FEEDER_ABORT_EN
    logic abort_hit;
    assign abort_hit = abort && (state != IDLE);
    assign kill      = reset || abort_hit;
`else
    assign kill      = reset;
`endif

    assign rd_en   = (state == FETCH);
    assign rd_addr = rd_en ? addr : '0;
    assign busy    = (state != IDLE);
    assign done    = (state == FINISH);
    assign active  = |vsh;

    // State, address and row/drain counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            addr  <= '0;
            cnt   <= '0;
        end else begin
            state <= nstate;
            addr  <= addr_n;
            cnt   <= cnt_n;
        end
    end

    // Next-state: fetch num_rows rows, then drain the skew for width_height cycles
    always_comb begin
        nstate = state;
        addr_n = addr;
        cnt_n  = cnt;
        unique case (state)
            IDLE: begin
                if (start) begin
                    addr_n = base_addr;
                    cnt_n  = num_rows;
                    nstate = (num_rows == '0) ? FINISH : FETCH;
                end
            end
            FETCH: begin
                addr_n = addr + ADDR_W'(1);
                cnt_n  = cnt - ADDR_W'(1);
                if (cnt == ADDR_W'(1)) begin
                    nstate = DRAIN;
                    cnt_n  = ADDR_W'(width_height - 1);
                end
            end
            DRAIN: begin
                cnt_n = cnt - ADDR_W'(1);
                if (cnt == '0) begin
                    nstate = FINISH;
                end
            end
            FINISH: begin
                nstate = IDLE;
            end
        endcase
`ifdef SYS_ARR_FEEDER_ABORT_EN
        if (abort_hit) begin
            nstate = IDLE;
        end
`endif
    end

`ifdef SYS_ARR_FEEDER_ABORT_EN
    // One-cycle acknowledge of an abort taken while busy
    always_ff @(posedge clk) begin
        if (reset) begin
            aborted <= 1'b0;
        end else begin
            aborted <= abort_hit;
        end
    end
`endif

    // Lane-valid chain: bit i marks lane i carrying a real element
    always_ff @(posedge clk) begin
        if (kill) begin
            vsh <= '0;
        end else begin
            vsh[0] <= rd_en;
            for (int i = 1; i < width_height; i++) begin
                vsh[i] <= vsh[i-1];
            end
        end
    end

    for (genvar g = 0; g < width_height; g++) begin : g_lane
        if (g == 0) begin : g_l0
            assign datain[7:0] = vsh[0] ? rd_data[7:0] : 8'h00;
        end else begin : g_ln
            logic [7:0] pipe [0:g-1];

            // Delay lane g by g cycles, zero-filled outside valid data
            always_ff @(posedge clk) begin
                if (kill) begin
                    for (int j = 0; j < g; j++) begin
                        pipe[j] <= 8'h00;
                    end
                end else begin
                    pipe[0] <= vsh[0] ? rd_data[8*g +: 8] : 8'h00;
                    for (int j = 1; j < g; j++) begin
                        pipe[j] <= pipe[j-1];
                    end
                end
            end

            assign datain[8*g +: 8] = pipe[g-1];
        end
    end

endmodule

// File: tb/tb_sys_arr_feeder.sv
// Randomised self-checking bench for sys_arr_feeder.
// Reference timing is derived per cycle from the start cycle.
module tb_sys_arr_feeder;

    localparam int W  = 4;
    localparam int AW = 8;
    localparam int DW = 8 * W;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW-1:0] num_rows;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data = '0;
    logic [DW-1:0] datain;
    logic          active;
    logic          busy;
    logic          done;
`ifdef SYS_ARR_FEEDER_ABORT_EN
    logic          abort = 1'b0;
    logic          aborted;
`endif

    logic [DW-1:0] mem [256];

    int checks = 0;
    int errors = 0;

    sys_arr_feeder #(.width_height(W), .ADDR_W(AW)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .base_addr (base_addr),
        .num_rows  (num_rows),
`ifdef SYS_ARR_FEEDER_ABORT_EN
        .abort     (abort),
        .aborted   (aborted),
`endif
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .datain    (datain),
        .active    (active),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Buffer model with one-cycle read latency
    always @(posedge clk) begin
        if (rd_en) rd_data <= mem[rd_addr];
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, required finish");
        $fatal(1);
    end

    // Run one operation from start to two cycles past done; check each cycle.
    task automatic run_op(input logic [7:0] b, input int n, input int restart_k);
        logic [DW-1:0] rows [$];
        logic [DW-1:0] exp_d;
        logic [7:0]    exp_a;
        int            donek;
        int            r;
        bit            exp_en, exp_act, exp_done, exp_busy;
        rows = {};
        for (int i = 0; i < n; i++) begin
            rows.push_back(mem[8'(int'(b) + i)]);
        end
        donek     = (n == 0) ? 1 : n + W + 1;
        base_addr = b;
        num_rows  = 8'(n);
        checks++;
        if (busy !== 1'b0 || active !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL pre_start: busy=%b active=%b done=%b required 000",
                     busy, active, done);
        end
        start = 1'b1;
        for (int k = 1; k <= donek + 2; k++) begin
            @(posedge clk);
            #1;
            start    = (k == restart_k);
            exp_en   = (k >= 1) && (k <= n);
            exp_a    = exp_en ? 8'(int'(b) + k - 1) : 8'h00;
            exp_act  = (n > 0) && (k >= 2) && (k <= n + W);
            exp_done = (k == donek);
            exp_busy = (k <= donek);
            exp_d    = '0;
            for (int i = 0; i < W; i++) begin
                r = k - 2 - i;
                if (r >= 0 && r < n) exp_d[8*i +: 8] = rows[r][8*i +: 8];
            end
            checks++;
            if (rd_en !== exp_en) begin
                errors++;
                $display("FAIL rd_en k=%0d: got %b required %b", k, rd_en, exp_en);
            end
            checks++;
            if (rd_addr !== exp_a) begin
                errors++;
                $display("FAIL rd_addr k=%0d: got %h required %h", k, rd_addr, exp_a);
            end
            checks++;
            if (datain !== exp_d) begin
                errors++;
                $display("FAIL datain k=%0d: got %h required %h", k, datain, exp_d);
            end
            checks++;
            if (active !== exp_act) begin
                errors++;
                $display("FAIL active k=%0d: got %b required %b", k, active, exp_act);
            end
            checks++;
            if (done !== exp_done) begin
                errors++;
                $display("FAIL done k=%0d: got %b required %b", k, done, exp_done);
            end
            checks++;
            if (busy !== exp_busy) begin
                errors++;
                $display("FAIL busy k=%0d: got %b required %b", k, busy, exp_busy);
            end
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        base_addr = '0;
        num_rows  = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({rd_en, rd_addr, datain, active, busy, done} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got en=%b a=%h d=%h act=%b busy=%b done=%b required all 0",
                     rd_en, rd_addr, datain, active, busy, done);
        end
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_uniform();
        for (int i = 0; i < 4; i++) mem[8'h10 + i] = 32'h0101_0101;
        run_op(8'h10, 4, 0);
    endtask

    task automatic test_distinct();
        logic [DW-1:0] v;
        for (int r = 0; r < 3; r++) begin
            v = '0;
            for (int i = 0; i < W; i++) v[8*i +: 8] = 8'(16 * r + i);
            mem[8'h40 + r] = v;
        end
        run_op(8'h40, 3, 0);
    endtask

    task automatic test_zero_rows();
        run_op(8'h33, 0, 0);
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 4; i++) mem[8'(8'hFE + i)] = $urandom;
        run_op(8'hFE, 4, 0);
    endtask

    task automatic test_start_ignored();
        run_op(8'h20, 5, 3);
    endtask

    task automatic test_random();
        for (int t = 0; t < 8; t++) begin
            run_op(8'($urandom), int'($urandom_range(1, 12)), 0);
        end
    endtask

    task automatic test_reset_in_drain();
        base_addr = 8'h50;
        num_rows  = 8'd4;
        start     = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({rd_en, rd_addr, datain, active, busy, done} !== '0) begin
            errors++;
            $display("FAIL reset_drain: got en=%b d=%h act=%b busy=%b done=%b required all 0",
                     rd_en, datain, active, busy, done);
        end
        reset = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
            checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL post_reset_idle k=%0d: done=%b busy=%b required 0 0",
                         k, done, busy);
            end
        end
    endtask

`ifdef SYS_ARR_FEEDER_ABORT_EN
    task automatic test_abort();
        base_addr = 8'h60;
        num_rows  = 8'd5;
        start     = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        checks++;
        if (active !== 1'b1) begin
            errors++;
            $display("FAIL abort_pre_active: got %b required 1", active);
        end
        abort = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        start = 1'b0;
        checks++;
        if ({active, datain, done, rd_en, busy} !== '0 || aborted !== 1'b1) begin
            errors++;
            $display("FAIL abort_effect: act=%b d=%h done=%b en=%b busy=%b aborted=%b required 0 0 0 0 0 1",
                     active, datain, done, rd_en, busy, aborted);
        end
        @(posedge clk);
        #1;
        checks++;
        if (aborted !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_pulse: aborted=%b busy=%b required 0 0", aborted, busy);
        end
        run_op(8'h70, 3, 0);
    endtask
`endif

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        test_reset();
        test_uniform();
        test_distinct();
        test_zero_rows();
        test_wrap();
        test_start_ignored();
        test_random();
        test_reset_in_drain();
`ifdef SYS_ARR_FEEDER_ABORT_EN
        test_abort();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
